// File: rtl/ohs_boost_axi_cfg_master_if.sv
// AXI4-Lite bus between the boost-model config master and the model's register slave.
interface ohs_boost_axi_cfg_master_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ohs_boost_axi_cfg_master.sv
// AXI4-Lite initiator: writes kL/kC/kR/vdc to the boost model and reads back its five outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for cfg_start / mon_start
// S_WR      | AW and W valid, each dropped after its own handshake
// S_WR_RESP | bready high, waiting for B
// S_RD_ADDR | arvalid high, waiting for arready
// S_RD_DATA | rready high, waiting for R
// S_FINISH  | done (and mon_valid) pulse cycle, then back to idle
module ohs_boost_axi_cfg_master #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] cfg_kL,
    input  logic [DATA_WIDTH-1:0] cfg_kC,
    input  logic [DATA_WIDTH-1:0] cfg_kR,
    input  logic [DATA_WIDTH-1:0] cfg_vdc,
    input  logic                  mon_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  err_timeout,
    output logic [DATA_WIDTH-1:0] mon_iL,
    output logic [DATA_WIDTH-1:0] mon_vL,
    output logic [DATA_WIDTH-1:0] mon_iC,
    output logic [DATA_WIDTH-1:0] mon_vC,
    output logic [DATA_WIDTH-1:0] mon_iLoad,
    output logic                  mon_valid,
    ohs_boost_axi_cfg_master_if.master m_axi
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_FINISH
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] RD_BASE = ADDR_WIDTH'(16);

    state_t                state;
    logic [2:0]            idx;
    logic [2:0]            idx_nxt;
    logic                  is_mon;
    logic [TW-1:0]         tcnt;
    logic [DATA_WIDTH-1:0] prm [4];
    logic                  aw_ok;
    logic                  w_ok;
    logic                  tc;

    assign m_axi.wstrb = {(DATA_WIDTH/8){1'b1}};

    always_comb begin
        idx_nxt = idx + 3'd1;
        aw_ok   = !m_axi.awvalid || m_axi.awready;
        w_ok    = !m_axi.wvalid || m_axi.wready;
        // Down-counter reaching zero is the terminal count; parameter 0 disables it.
        tc      = (TIMEOUT_CYCLES != 0) && (tcnt == '0);
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            is_mon        <= 1'b0;
            tcnt          <= '0;
            for (int i = 0; i < 4; i++) prm[i] <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_timeout   <= 1'b0;
            mon_iL        <= '0;
            mon_vL        <= '0;
            mon_iC        <= '0;
            mon_vC        <= '0;
            mon_iLoad     <= '0;
            mon_valid     <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
        end else begin
            done      <= 1'b0;
            mon_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // cfg has priority; a simultaneous mon_start is dropped.
                    if (cfg_start) begin
                        prm[0]        <= cfg_kL;
                        prm[1]        <= cfg_kC;
                        prm[2]        <= cfg_kR;
                        prm[3]        <= cfg_vdc;
                        idx           <= '0;
                        is_mon        <= 1'b0;
                        err           <= 1'b0;
                        err_timeout   <= 1'b0;
                        busy          <= 1'b1;
                        m_axi.awaddr  <= '0;
                        m_axi.wdata   <= cfg_kL;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wvalid  <= 1'b1;
                        tcnt          <= TO_LOAD;
                        state         <= S_WR;
                    end else if (mon_start) begin
                        idx           <= '0;
                        is_mon        <= 1'b1;
                        err           <= 1'b0;
                        err_timeout   <= 1'b0;
                        busy          <= 1'b1;
                        m_axi.araddr  <= RD_BASE;
                        m_axi.arvalid <= 1'b1;
                        tcnt          <= TO_LOAD;
                        state         <= S_RD_ADDR;
                    end
                end
                S_WR: begin
                    if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wvalid && m_axi.wready) m_axi.wvalid <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi.bready <= 1'b1;
                        tcnt         <= TO_LOAD;
                        state        <= S_WR_RESP;
                    end else if (tc) begin
                        m_axi.awvalid <= 1'b0;
                        m_axi.wvalid  <= 1'b0;
                        err           <= 1'b1;
                        err_timeout   <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_FINISH;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_WR_RESP: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        if (m_axi.bresp != 2'b00 || idx == 3'd3) begin
                            if (m_axi.bresp != 2'b00) err <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            idx           <= idx_nxt;
                            m_axi.awaddr  <= ADDR_WIDTH'({idx_nxt, 2'b00});
                            m_axi.wdata   <= prm[idx_nxt[1:0]];
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            tcnt          <= TO_LOAD;
                            state         <= S_WR;
                        end
                    end else if (tc) begin
                        m_axi.bready <= 1'b0;
                        err          <= 1'b1;
                        err_timeout  <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= S_FINISH;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_RD_ADDR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        tcnt          <= TO_LOAD;
                        state         <= S_RD_DATA;
                    end else if (tc) begin
                        m_axi.arvalid <= 1'b0;
                        err           <= 1'b1;
                        err_timeout   <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_FINISH;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_RD_DATA: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        // Data is kept even on an error response to aid debug.
                        case (idx)
                            3'd0:    mon_iL    <= m_axi.rdata;
                            3'd1:    mon_vL    <= m_axi.rdata;
                            3'd2:    mon_iC    <= m_axi.rdata;
                            3'd3:    mon_vC    <= m_axi.rdata;
                            default: mon_iLoad <= m_axi.rdata;
                        endcase
                        if (m_axi.rresp != 2'b00) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else if (idx == 3'd4) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            mon_valid <= is_mon;
                            state     <= S_FINISH;
                        end else begin
                            idx           <= idx_nxt;
                            m_axi.araddr  <= RD_BASE + ADDR_WIDTH'({idx_nxt, 2'b00});
                            m_axi.arvalid <= 1'b1;
                            tcnt          <= TO_LOAD;
                            state         <= S_RD_ADDR;
                        end
                    end else if (tc) begin
                        m_axi.rready <= 1'b0;
                        err          <= 1'b1;
                        err_timeout  <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= S_FINISH;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ohs_boost_axi_cfg_master.sv
// Scoreboarded bench for ohs_boost_axi_cfg_master against a parameter-driven AXI4-Lite slave model.
module tb_ohs_boost_axi_cfg_master;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_start = 1'b0;
    logic          mon_start = 1'b0;
    logic [DW-1:0] cfg_kL = '0, cfg_kC = '0, cfg_kR = '0, cfg_vdc = '0;
    logic          busy, done, err, err_timeout, mon_valid;
    logic [DW-1:0] mon_iL, mon_vL, mon_iC, mon_vC, mon_iLoad;

    ohs_boost_axi_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    ohs_boost_axi_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .reset(reset), .cfg_start(cfg_start),
        .cfg_kL(cfg_kL), .cfg_kC(cfg_kC), .cfg_kR(cfg_kR), .cfg_vdc(cfg_vdc),
        .mon_start(mon_start), .busy(busy), .done(done), .err(err), .err_timeout(err_timeout),
        .mon_iL(mon_iL), .mon_vL(mon_vL), .mon_iC(mon_iC), .mon_vC(mon_vC), .mon_iLoad(mon_iLoad),
        .mon_valid(mon_valid), .m_axi(axi)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;

    int aw_delay = 0;
    int w_delay = 0;
    int err_at = -1;
    bit ar_stuck = 1'b0;
    logic [DW-1:0] rd_mem [5];

    bit            aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [AW-1:0] aw_cap;
    logic [DW-1:0] w_cap;
    logic [3:0]    strb_cap;
    int            r_idx = 0;
    int            b_count = 0, ar_count = 0, done_count = 0;
    wr_exp_t       exp_wr [$];
    logic [AW-1:0] exp_ar [$];

    // Bus monitor / scoreboard: observes handshakes on the active edge.
    always @(posedge aclk) begin
        if (reset) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        end else begin
            if (done) done_count++;
            if (axi.awvalid && axi.awready) begin aw_got = 1; aw_cap = axi.awaddr; end
            if (axi.wvalid && axi.wready) begin w_got = 1; w_cap = axi.wdata; strb_cap = axi.wstrb; end
            if (axi.bvalid && axi.bready) begin b_pend = 0; b_count++; end
            if (aw_got && w_got && !b_pend) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got addr=%h data=%h expected no write", aw_cap, w_cap);
                end else begin
                    wr_exp_t e;
                    e = exp_wr.pop_front();
                    if ({aw_cap, w_cap, strb_cap} !== {e.addr, e.data, 4'hF}) begin
                        bad++;
                        $display("FAIL wr_beat got addr=%h data=%h strb=%h expected addr=%h data=%h strb=f",
                                 aw_cap, w_cap, strb_cap, e.addr, e.data);
                    end
                end
                aw_got = 0; w_got = 0; b_pend = 1;
            end
            if (axi.rvalid && axi.rready) r_pend = 0;
            if (axi.arvalid && axi.arready) begin
                ar_count++;
                total++;
                if (exp_ar.size() == 0) begin
                    bad++;
                    $display("FAIL ar_unexpected got addr=%h expected no read", axi.araddr);
                    r_idx = 0;
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_ar.pop_front();
                    if (axi.araddr !== ea) begin
                        bad++;
                        $display("FAIL ar_addr got=%h expected=%h", axi.araddr, ea);
                    end
                    r_idx = (int'(ea) - 16) / 4;
                end
                r_pend = 1;
            end
        end
    end

    // Slave response driver, updated away from the active edge.
    int aw_cnt = 0, w_cnt = 0;
    always @(negedge aclk) begin
        if (reset) begin
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
            axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
            aw_cnt = 0; w_cnt = 0;
        end else begin
            axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
            if (axi.awvalid) aw_cnt++; else aw_cnt = 0;
            axi.wready = axi.wvalid && (w_cnt >= w_delay);
            if (axi.wvalid) w_cnt++; else w_cnt = 0;
            axi.bvalid  = b_pend;
            axi.bresp   = (b_pend && b_count == err_at) ? 2'b10 : 2'b00;
            axi.arready = axi.arvalid && !ar_stuck;
            axi.rvalid  = r_pend;
            axi.rdata   = (r_pend && r_idx >= 0 && r_idx < 5) ? rd_mem[r_idx] : '0;
            axi.rresp   = 2'b00;
        end
    end

    task automatic push_writes(input logic [DW-1:0] a, b, c, d, input int n);
        logic [DW-1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < n; i++) exp_wr.push_back('{AW'(i * 4), v[i]});
    endtask

    // Returns in cycle 1 (the cycle after the accepting edge).
    task automatic start_cfg(input logic [DW-1:0] a, b, c, d, input bit with_mon);
        @(negedge aclk);
        cfg_kL = a; cfg_kC = b; cfg_kR = c; cfg_vdc = d;
        cfg_start = 1; mon_start = with_mon;
        @(negedge aclk);
        cfg_start = 0; mon_start = 0;
    endtask

    task automatic start_mon();
        @(negedge aclk);
        mon_start = 1;
        @(negedge aclk);
        mon_start = 0;
    endtask

    task automatic wait_done(input int first, input int max, output int cyc, output int busy_cnt);
        cyc = first;
        busy_cnt = 0;
        while (!done && cyc < max) begin
            busy_cnt += int'(busy);
            @(negedge aclk);
            cyc++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_wait got no done by cycle %0d expected done", cyc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        total++;
        if ({busy, done, err, err_timeout, mon_valid} !== 5'b0) begin
            bad++; $display("FAIL rst_status got=%b expected=00000", {busy, done, err, err_timeout, mon_valid});
        end
        total++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
            bad++; $display("FAIL rst_handshake got=%b expected=00000",
                            {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        end
        total++;
        if ({mon_iL, mon_vL, mon_iC, mon_vC, mon_iLoad} !== '0) begin
            bad++; $display("FAIL rst_mon got nonzero mon_* expected all zero");
        end
        total++;
        if ({axi.awaddr, axi.araddr, axi.wdata} !== '0) begin
            bad++; $display("FAIL rst_addr got aw=%h ar=%h wd=%h expected 0", axi.awaddr, axi.araddr, axi.wdata);
        end
        reset = 0;
        @(negedge aclk);
    endtask

    task automatic test_cfg_zero_wait();
        int cyc, bc, b0;
        b0 = b_count;
        push_writes(32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC, 32'h00C8_0000, 4);
        start_cfg(32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC, 32'h00C8_0000, 0);
        total++;
        if ({axi.awvalid, axi.wvalid, busy} !== 3'b111) begin
            bad++; $display("FAIL cfg_cycle1 got aw/w/busy=%b expected=111", {axi.awvalid, axi.wvalid, busy});
        end
        wait_done(1, 50, cyc, bc);
        total++;
        if (cyc !== 9) begin bad++; $display("FAIL cfg_done_cycle got=%0d expected=9", cyc); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL cfg_busy_cycles got=%0d expected=8", bc); end
        total++;
        if ({busy, err, mon_valid} !== 3'b000) begin
            bad++; $display("FAIL cfg_end_flags got busy/err/mon_valid=%b expected=000", {busy, err, mon_valid});
        end
        total++;
        if (b_count - b0 !== 4 || exp_wr.size() !== 0) begin
            bad++; $display("FAIL cfg_write_count got b=%0d left=%0d expected b=4 left=0", b_count - b0, exp_wr.size());
        end
    endtask

    task automatic test_aw_stall();
        int cyc, aw_hi, w_hi, b0;
        aw_delay = 3;
        b0 = b_count;
        push_writes(32'hA1, 32'hB2, 32'hC3, 32'hD4, 4);
        start_cfg(32'hA1, 32'hB2, 32'hC3, 32'hD4, 0);
        cyc = 1; aw_hi = 0; w_hi = 0;
        while (!done && cyc < 100) begin
            if (b_count == b0) begin aw_hi += int'(axi.awvalid); w_hi += int'(axi.wvalid); end
            @(negedge aclk);
            cyc++;
        end
        total++;
        if (aw_hi !== 4 || w_hi !== 1) begin
            bad++; $display("FAIL stall_valid_len got aw=%0d w=%0d expected aw=4 w=1", aw_hi, w_hi);
        end
        total++;
        if (done !== 1'b1 || cyc !== 21) begin
            bad++; $display("FAIL stall_done got done=%b cycle=%0d expected done=1 cycle=21", done, cyc);
        end
        total++;
        if (b_count - b0 !== 4 || err !== 1'b0 || exp_wr.size() !== 0) begin
            bad++; $display("FAIL stall_complete got b=%0d err=%b left=%0d expected b=4 err=0 left=0",
                            b_count - b0, err, exp_wr.size());
        end
        aw_delay = 0;
    endtask

    task automatic test_monitor();
        int cyc, bc;
        logic [DW-1:0] want [5];
        for (int i = 0; i < 5; i++) begin
            want[i] = DW'((i + 1) * 32'h11);
            rd_mem[i] = want[i];
            exp_ar.push_back(AW'(16 + i * 4));
        end
        start_mon();
        wait_done(1, 50, cyc, bc);
        total++;
        if (cyc !== 11 || bc !== 10) begin
            bad++; $display("FAIL mon_timing got done_cycle=%0d busy=%0d expected 11 and 10", cyc, bc);
        end
        total++;
        if (mon_valid !== 1'b1) begin bad++; $display("FAIL mon_valid_pulse got=%b expected=1", mon_valid); end
        total++;
        if ({mon_iL, mon_vL, mon_iC, mon_vC, mon_iLoad} !== {want[0], want[1], want[2], want[3], want[4]}) begin
            bad++; $display("FAIL mon_values got %h %h %h %h %h expected %h %h %h %h %h",
                            mon_iL, mon_vL, mon_iC, mon_vC, mon_iLoad, want[0], want[1], want[2], want[3], want[4]);
        end
        total++;
        if (err !== 1'b0 || exp_ar.size() !== 0) begin
            bad++; $display("FAIL mon_clean got err=%b left=%0d expected err=0 left=0", err, exp_ar.size());
        end
        @(negedge aclk);
        total++;
        if (mon_valid !== 1'b0) begin bad++; $display("FAIL mon_valid_width got=%b expected=0", mon_valid); end
    endtask

    task automatic test_bresp_err();
        int cyc, bc, b0;
        b0 = b_count;
        err_at = b_count + 1;
        push_writes(32'h10, 32'h20, 32'h30, 32'h40, 2);
        start_cfg(32'h10, 32'h20, 32'h30, 32'h40, 0);
        wait_done(1, 50, cyc, bc);
        total++;
        if (cyc !== 5) begin bad++; $display("FAIL berr_done_cycle got=%0d expected=5", cyc); end
        total++;
        if ({err, err_timeout, mon_valid} !== 3'b100) begin
            bad++; $display("FAIL berr_flags got err/tmo/mon_valid=%b expected=100", {err, err_timeout, mon_valid});
        end
        repeat (3) @(negedge aclk);
        total++;
        if (b_count - b0 !== 2 || exp_wr.size() !== 0 || err !== 1'b1) begin
            bad++; $display("FAIL berr_writes got b=%0d left=%0d err=%b expected b=2 left=0 err=1",
                            b_count - b0, exp_wr.size(), err);
        end
        err_at = -1;
        push_writes(32'h50, 32'h60, 32'h70, 32'h80, 4);
        start_cfg(32'h50, 32'h60, 32'h70, 32'h80, 0);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL berr_clear got err=%b expected=0", err); end
        wait_done(1, 50, cyc, bc);
    endtask

    task automatic test_timeout();
        int cyc, ar_hi, a0;
        ar_stuck = 1;
        a0 = ar_count;
        start_mon();
        cyc = 1; ar_hi = 0;
        while (!done && cyc < 100) begin
            ar_hi += int'(axi.arvalid);
            @(negedge aclk);
            cyc++;
        end
        total++;
        if (ar_hi !== 16 || cyc !== 17) begin
            bad++; $display("FAIL tmo_len got arvalid_cycles=%0d done_cycle=%0d expected 16 and 17", ar_hi, cyc);
        end
        total++;
        if ({done, err, err_timeout, mon_valid, axi.arvalid} !== 5'b11100) begin
            bad++; $display("FAIL tmo_flags got done/err/tmo/mon_valid/arvalid=%b expected=11100",
                            {done, err, err_timeout, mon_valid, axi.arvalid});
        end
        total++;
        if (ar_count !== a0) begin bad++; $display("FAIL tmo_no_ar got=%0d expected=%0d", ar_count, a0); end
        ar_stuck = 0;
    endtask

    task automatic test_same_cycle();
        int cyc, bc, a0;
        a0 = ar_count;
        push_writes(32'h1, 32'h2, 32'h3, 32'h4, 4);
        start_cfg(32'h1, 32'h2, 32'h3, 32'h4, 1);
        total++;
        if ({err, err_timeout, axi.arvalid} !== 3'b000) begin
            bad++; $display("FAIL both_start_clear got err/tmo/arvalid=%b expected=000", {err, err_timeout, axi.arvalid});
        end
        wait_done(1, 50, cyc, bc);
        total++;
        if (cyc !== 9 || mon_valid !== 1'b0) begin
            bad++; $display("FAIL both_done got cycle=%0d mon_valid=%b expected 9 and 0", cyc, mon_valid);
        end
        repeat (4) @(negedge aclk);
        total++;
        if (ar_count !== a0 || busy !== 1'b0 || exp_wr.size() !== 0) begin
            bad++; $display("FAIL both_mon_dropped got ar=%0d busy=%b left=%0d expected ar=%0d busy=0 left=0",
                            ar_count, busy, exp_wr.size(), a0);
        end
    endtask

    task automatic test_busy_start();
        int cyc, bc, a0, d0;
        a0 = ar_count;
        d0 = done_count;
        push_writes(32'hAA, 32'hBB, 32'hCC, 32'hDD, 4);
        start_cfg(32'hAA, 32'hBB, 32'hCC, 32'hDD, 0);
        cfg_kL = 32'hEE; cfg_kC = 32'hEE; cfg_kR = 32'hEE; cfg_vdc = 32'hEE;
        cfg_start = 1; mon_start = 1;
        @(negedge aclk);
        cfg_start = 0; mon_start = 0;
        wait_done(2, 50, cyc, bc);
        total++;
        if (cyc !== 9) begin bad++; $display("FAIL busy_start_done got=%0d expected=9", cyc); end
        repeat (12) @(negedge aclk);
        total++;
        if (busy !== 1'b0 || done_count - d0 !== 1 || ar_count !== a0 || exp_wr.size() !== 0) begin
            bad++; $display("FAIL busy_start_ignored got busy=%b dones=%0d ar=%0d left=%0d expected 0 1 %0d 0",
                            busy, done_count - d0, ar_count, exp_wr.size(), a0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc, d0;
        d0 = done_count;
        push_writes(32'h5, 32'h6, 32'h7, 32'h8, 4);
        start_cfg(32'h5, 32'h6, 32'h7, 32'h8, 0);
        repeat (2) @(negedge aclk);
        reset = 1;
        #1;
        total++;
        if ({busy, done, err, axi.awvalid, axi.wvalid, axi.bready} !== 6'b0) begin
            bad++; $display("FAIL midrst_outputs got=%b expected=000000",
                            {busy, done, err, axi.awvalid, axi.wvalid, axi.bready});
        end
        total++;
        if ({mon_iL, mon_iLoad, axi.awaddr, axi.wdata} !== '0) begin
            bad++; $display("FAIL midrst_regs got mon_iL=%h awaddr=%h wdata=%h expected 0", mon_iL, axi.awaddr, axi.wdata);
        end
        repeat (2) @(negedge aclk);
        reset = 0;
        exp_wr.delete();
        repeat (15) @(negedge aclk);
        total++;
        if (done_count !== d0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_no_done got dones=%0d busy=%b expected 0 and 0", done_count - d0, busy);
        end
        push_writes(32'h9, 32'hA, 32'hB, 32'hC, 4);
        start_cfg(32'h9, 32'hA, 32'hB, 32'hC, 0);
        wait_done(1, 50, cyc, bc);
        total++;
        if (cyc !== 9 || err !== 1'b0) begin
            bad++; $display("FAIL midrst_recover got cycle=%0d err=%b expected 9 and 0", cyc, err);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_zero_wait();
        test_aw_stall();
        test_monitor();
        test_bresp_err();
        test_timeout();
        test_same_cycle();
        test_busy_start();
        test_reset_mid();
        repeat (3) @(negedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no end of test by 200000 expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ohs_boost_axi_cfg_master.md
# ohs_boost_axi_cfg_master

AXI4-Lite initiator that drives the boost model's register interface from the fabric side. On command it writes the four model parameters (kL, kC, kR, vdc) to the boost model's AXI4-Lite slave. On a separate command it reads back the five model outputs (iL, vL, iC, vC, iLoad). It sits between a local controller (sequencer, testbench or soft CPU bridge) and the boost model wrapper. One transaction is outstanding at a time.

## Interface
- ADDR_WIDTH, 6, AXI address width; matches the model slave.
- DATA_WIDTH, 32, AXI data width; fixed at 32.
- TIMEOUT_CYCLES, 1024, maximum wait per handshake phase; 0 disables the timeout.
- aclk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_start  in  1  pulse; starts the 4-write parameter sequence.
- cfg_kL, cfg_kC, cfg_kR, cfg_vdc  in  32 each  parameter values; captured on an accepted cfg_start.
- mon_start  in  1  pulse; starts the 5-read monitor sequence.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse at sequence end, whether it succeeded or failed.
- err  out  1  sticky; set on non-OKAY response or timeout; cleared on the next accepted start.
- err_timeout  out  1  sticky; qualifies err as a timeout; cleared with err.
- mon_iL, mon_vL, mon_iC, mon_vC, mon_iLoad  out  32 each  last read values.
- mon_valid  out  1  1-cycle pulse, coincident with done, only after a successful monitor sequence.
- m_axi_awaddr  out  ADDR_WIDTH; m_axi_awvalid out 1; m_axi_awready in 1.
- m_axi_wdata  out  32; m_axi_wstrb out 4 (always 4'hF); m_axi_wvalid out 1; m_axi_wready in 1.
- m_axi_bresp  in  2; m_axi_bvalid in 1; m_axi_bready out 1.
- m_axi_araddr  out  ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1.
- m_axi_rdata  in  32; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

## Operation
- Register map (byte addresses): kL 0x00, kC 0x04, kR 0x08, vdc 0x0C, iL 0x10, vL 0x14, iC 0x18, vC 0x1C, iLoad 0x20.
- FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, FINISH. A 3-bit index counts 0..3 for writes and 0..4 for reads.
- IDLE:
  - cfg_start → WR with idx=0; parameters are latched.
  - mon_start → RD_ADDR with idx=0.
  - If both arrive in the same cycle, cfg wins and mon_start is dropped (not queued).
  - Starts arriving while busy are ignored.
- WR:
  - awvalid and wvalid rise together.
  - Each is held until its own ready is seen. AW and W may complete in different cycles; each valid drops independently after its handshake.
  - When both have completed → WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: if bresp≠00, set err and go to FINISH (remaining writes are skipped).
  - Else idx==3 → FINISH, otherwise idx++ → WR.
- RD_ADDR: arvalid=1 until arready → RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: store rdata into mon_* selected by idx, regardless of rresp.
  - If rresp≠00, set err → FINISH.
  - Else idx==4 → FINISH, otherwise idx++ → RD_ADDR.
- FINISH: done=1 for one cycle; mon_valid=1 if this was a monitor sequence and err=0; → IDLE.
- Timeout:
  - A counter clears on entry to each WR/WR_RESP/RD_ADDR/RD_DATA state.
  - Reaching TIMEOUT_CYCLES sets err and err_timeout, deasserts all valids and readies, → FINISH.
  - This abort is a debug escape and is not AXI-compliant; the slave must be reset before reuse.
- awaddr/araddr/wdata are registered and stable while the corresponding valid is high.
- Reset values: all valids/readies 0, busy 0, done 0, err 0, err_timeout 0, mon_* 0, mon_valid 0, addresses/wdata 0, FSM in IDLE. Reset mid-sequence aborts immediately with no done pulse.

## Timing
- awvalid, wvalid and arvalid assert the cycle after the accepted start (cycle 1).
- The bready/rready state is entered the cycle after the address/data handshake completes.
- With a zero-wait slave (readies high, response one cycle after the handshake):
  - Each write takes 2 cycles and each read takes 2 cycles.
  - Config sequence: busy for 8 cycles, done in cycle 9.
  - Monitor sequence: busy for 10 cycles, done in cycle 11.
- busy deasserts in the same cycle done is high. A new start is accepted the cycle after done.
- No combinational path from any AXI input to any AXI output.

## Test plan
- Config, zero-wait slave model: kL=0x00001234, kC=0x00005678, kR=0x00009ABC, vdc=0x00C80000 → writes to 0x00, 0x04, 0x08 and 0x0C in order with wstrb=F; done at cycle 9; err=0.
- Independent AW/W stall: awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles, a single B is accepted, and the sequence completes.
- Monitor: slave returns 0x11, 0x22, 0x33, 0x44, 0x55 → mon_iL..mon_iLoad hold those values; mon_valid pulses with done at cycle 11.
- Error: bresp=2'b10 on the second write → err=1, no third write is issued, done pulses, mon_valid=0; the next cfg_start clears err.
- Timeout with TIMEOUT_CYCLES=16 and arready stuck at 0 → arvalid drops after 16 cycles; err=1, err_timeout=1, done pulses.
- cfg_start and mon_start in the same cycle → only the 4 writes occur. A start while busy, or reset asserted mid-write, is ignored/aborted: all outputs return to 0 and no done pulse is produced.
